mem_access_stage: RTL and testbench

//   MEM pipeline stage of the Balotelli core, between Ex2Mem and Mem2Wb.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_align.sv | 55 +++++
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared funct3 size codes and FSM state encoding for the MEM stage
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // log2 of the access size in bytes; bit 2 of funct3 only selects zero-extension
    function automatic logic [1:0] size_log2(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - combinational load extract/extend and store strobe/data lane placement
module mem_align
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]          i_funct3,
    input  logic [LANE_W-1:0]   i_lane,
    input  logic [XLEN-1:0]     i_store_data,
    input  logic [XLEN-1:0]     i_rdata,
    output logic [XLEN/8-1:0]   o_wstrb,
    output logic [XLEN-1:0]     o_wdata,
    output logic [XLEN-1:0]     o_load_data
);

    localparam int NLANE = XLEN / 8;

    logic [1:0]        w_size;
    logic [LANE_W-1:0] w_lane;
    logic [NLANE-1:0]  w_mask;
    logic [XLEN-1:0]   w_shifted;
    logic              w_signed;

    assign w_size = size_log2(i_funct3);

    // Address bits below the access size are dropped, so a misaligned access lands on its natural lanes
    assign w_lane = i_lane & ~((LANE_W'(1) << w_size) - LANE_W'(1));

    always_comb begin
        w_mask = '1;
        case (w_size)
            2'd0:    w_mask = NLANE'(1);
            2'd1:    w_mask = NLANE'(3);
            2'd2:    w_mask = NLANE'(15);
            default: w_mask = '1;
        endcase
    end

    assign o_wstrb   = w_mask << w_lane;
    assign o_wdata   = i_store_data << {w_lane, 3'b000};
    assign w_shifted = i_rdata >> {w_lane, 3'b000};
    assign w_signed  = ~i_funct3[2];

    always_comb begin
        o_load_data = w_shifted;
        case (w_size)
            2'd0:    o_load_data = {{(XLEN-8){w_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    o_load_data = {{(XLEN-16){w_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    o_load_data = {{(XLEN-32){w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_load_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory req/gnt/rvalid FSM, rd forwarding, stall
// Optional MISALIGN_TRAP_EN adds MisalignOut and suppresses misaligned H/W/D accesses.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 5
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                ValidIn,
    input  logic                MemReadIn,
    input  logic                MemWriteIn,
    input  logic [2:0]          Funct3In,
    input  logic [XLEN-1:0]     AluResultIn,
    input  logic [XLEN-1:0]     StoreDataIn,
    input  logic [ADDR_W-1:0]   RdAddrIn,
    input  logic                RdWriteEnableIn,
    output logic                StallReq,
    output logic                DmemReq,
    output logic                DmemWe,
    output logic [XLEN-1:0]     DmemAddr,
    output logic [XLEN-1:0]     DmemWdata,
    output logic [XLEN/8-1:0]   DmemWstrb,
    input  logic                DmemGnt,
    input  logic                DmemRvalid,
    input  logic [XLEN-1:0]     DmemRdata,
`ifdef MISALIGN_TRAP_EN
    output logic                MisalignOut,
`endif
    output logic [XLEN-1:0]     RdWriteDataOut,
    output logic [ADDR_W-1:0]   RdAddrOut,
    output logic                RdWriteEnableOut
);

    localparam int LANE_W = $clog2(XLEN / 8);

    mem_state_e          r_state;
    mem_state_e          w_next;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_store_data;
    logic [2:0]          r_funct3;
    logic                r_we;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_we;
    logic [XLEN-1:0]     r_load_data;

    logic                w_idle;
    logic                w_mem_op;
    logic                w_trap;
    logic                w_issue;
    logic                w_latch;
    logic                w_capture;
    logic [XLEN-1:0]     w_sel_addr;
    logic [XLEN-1:0]     w_sel_data;
    logic [2:0]          w_sel_f3;
    logic [XLEN-1:0]     w_aligned_addr;
    logic [XLEN/8-1:0]   w_wstrb;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_load_data;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_mem_op = ValidIn & (MemReadIn | MemWriteIn);

`ifdef MISALIGN_TRAP_EN
    logic [LANE_W-1:0] w_low_mask;
    assign w_low_mask  = (LANE_W'(1) << Funct3In[1:0]) - LANE_W'(1);
    assign w_trap      = w_mem_op & (|(AluResultIn[LANE_W-1:0] & w_low_mask));
    assign MisalignOut = ~Rst & w_idle & w_trap;
`else
    assign w_trap = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_trap;

    // Live inputs drive the port in IDLE; afterwards the latched copy keeps it stable
    assign w_sel_addr     = w_idle ? AluResultIn : r_addr;
    assign w_sel_data     = w_idle ? StoreDataIn : r_store_data;
    assign w_sel_f3       = w_idle ? Funct3In    : r_funct3;
    assign w_aligned_addr = {w_sel_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};

    mem_align #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W)
    ) u_mem_align (
        .i_funct3     (w_sel_f3),
        .i_lane       (w_sel_addr[LANE_W-1:0]),
        .i_store_data (w_sel_data),
        .i_rdata      (DmemRdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_next           = r_state;
        w_latch          = 1'b0;
        w_capture        = 1'b0;
        StallReq         = 1'b0;
        DmemReq          = 1'b0;
        DmemWe           = 1'b0;
        DmemAddr         = '0;
        DmemWdata        = '0;
        DmemWstrb        = '0;
        RdWriteDataOut   = '0;
        RdAddrOut        = '0;
        RdWriteEnableOut = 1'b0;

        case (r_state)
            ST_IDLE: begin
                RdWriteDataOut   = AluResultIn;
                RdAddrOut        = RdAddrIn;
                RdWriteEnableOut = ValidIn & RdWriteEnableIn & ~w_trap;
                if (w_issue) begin
                    DmemReq   = 1'b1;
                    DmemWe    = MemWriteIn;
                    DmemAddr  = w_aligned_addr;
                    DmemWdata = w_wdata;
                    DmemWstrb = w_wstrb;
                    w_latch   = 1'b1;
                    if (!DmemGnt) begin
                        w_next   = ST_REQ;
                        StallReq = 1'b1;
                    end else if (!MemWriteIn) begin
                        w_next   = ST_RESP;
                        StallReq = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                DmemReq   = 1'b1;
                DmemWe    = r_we;
                DmemAddr  = w_aligned_addr;
                DmemWdata = w_wdata;
                DmemWstrb = w_wstrb;
                // A store retires on its grant cycle, releasing upstream one cycle early
                StallReq  = ~(DmemGnt & r_we);
                RdAddrOut = r_rd_addr;
                RdWriteEnableOut = r_rd_we;
                if (DmemGnt) begin
                    w_next = r_we ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                StallReq = 1'b1;
                if (DmemRvalid) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                RdWriteDataOut   = r_load_data;
                RdAddrOut        = r_rd_addr;
                RdWriteEnableOut = r_rd_we;
                w_next           = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        if (StallReq) begin
            RdWriteEnableOut = 1'b0;
        end

        if (Rst) begin
            StallReq         = 1'b0;
            DmemReq          = 1'b0;
            DmemWe           = 1'b0;
            DmemAddr         = '0;
            DmemWdata        = '0;
            DmemWstrb        = '0;
            RdWriteDataOut   = '0;
            RdAddrOut        = '0;
            RdWriteEnableOut = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_store_data <= '0;
            r_funct3     <= '0;
            r_we         <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_we      <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr       <= AluResultIn;
                r_store_data <= StoreDataIn;
                r_funct3     <= Funct3In;
                r_we         <= MemWriteIn;
                r_rd_addr    <= RdAddrIn;
                r_rd_we      <= ValidIn & RdWriteEnableIn;
            end
            if (w_capture) begin
                r_load_data <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage (vector table, directed and random)
module tb_mem_access_stage;
    import mem_access_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        ValidIn;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic [2:0]  Funct3In;
    logic [63:0] AluResultIn;
    logic [63:0] StoreDataIn;
    logic [4:0]  RdAddrIn;
    logic        RdWriteEnableIn;
    logic        StallReq;
    logic        DmemReq;
    logic        DmemWe;
    logic [63:0] DmemAddr;
    logic [63:0] DmemWdata;
    logic [7:0]  DmemWstrb;
    logic        DmemGnt;
    logic        DmemRvalid;
    logic [63:0] DmemRdata;
    logic [63:0] RdWriteDataOut;
    logic [4:0]  RdAddrOut;
    logic        RdWriteEnableOut;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignOut;
`endif

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.XLEN(64), .ADDR_W(5)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .ValidIn          (ValidIn),
        .MemReadIn        (MemReadIn),
        .MemWriteIn       (MemWriteIn),
        .Funct3In         (Funct3In),
        .AluResultIn      (AluResultIn),
        .StoreDataIn      (StoreDataIn),
        .RdAddrIn         (RdAddrIn),
        .RdWriteEnableIn  (RdWriteEnableIn),
        .StallReq         (StallReq),
        .DmemReq          (DmemReq),
        .DmemWe           (DmemWe),
        .DmemAddr         (DmemAddr),
        .DmemWdata        (DmemWdata),
        .DmemWstrb        (DmemWstrb),
        .DmemGnt          (DmemGnt),
        .DmemRvalid       (DmemRvalid),
        .DmemRdata        (DmemRdata),
`ifdef MISALIGN_TRAP_EN
        .MisalignOut      (MisalignOut),
`endif
        .RdWriteDataOut   (RdWriteDataOut),
        .RdAddrOut        (RdAddrOut),
        .RdWriteEnableOut (RdWriteEnableOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidIn = 0; MemReadIn = 0; MemWriteIn = 0; Funct3In = 0;
        AluResultIn = 0; StoreDataIn = 0; RdAddrIn = 0; RdWriteEnableIn = 0;
        DmemGnt = 0; DmemRvalid = 0; DmemRdata = 0;
    endtask

    function automatic logic [63:0] bytemask(input logic [7:0] strb);
        logic [63:0] m;
        m = 0;
        for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference: access of 2^f3[1:0] bytes at its naturally aligned lane within the 8-byte word
    function automatic int ref_lane(input logic [2:0] f3, input logic [63:0] addr);
        int nb;
        nb = 1 << f3[1:0];
        return (int'(addr[2:0]) / nb) * nb;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rd);
        int nb;
        logic [63:0] v;
        logic [63:0] m;
        nb = 1 << f3[1:0];
        v = rd >> (ref_lane(f3, addr) * 8);
        if (nb < 8) begin
            m = (64'd1 << (nb * 8)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[nb*8-1]) v = v | ~m;
        end
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] addr);
        int nb;
        nb = 1 << f3[1:0];
        return 8'(((1 << nb) - 1) << ref_lane(f3, addr));
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] addr,
                                              input logic [63:0] sd);
        return (sd << (ref_lane(f3, addr) * 8)) & bytemask(ref_strb(f3, addr));
    endfunction

    task automatic do_mem(input string nm, input logic is_load, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                          input int gnt_dly, input int rv_dly, input logic [4:0] rd,
                          input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_load,
                          output int stalls);
        logic exp_stall;
        stalls = 0;
        ValidIn = 1; MemReadIn = is_load; MemWriteIn = !is_load; Funct3In = f3;
        AluResultIn = addr; StoreDataIn = sdata; RdAddrIn = rd; RdWriteEnableIn = is_load;
        DmemRvalid = 0; DmemRdata = rdata;
        for (int i = 0; i <= gnt_dly; i++) begin
            DmemGnt = (i == gnt_dly);
            #4;
            exp_stall = is_load || (i != gnt_dly);
            chk({nm, " req"}, DmemReq, 1);
            chk({nm, " addr"}, DmemAddr, exp_addr);
            chk({nm, " we"}, DmemWe, !is_load);
            chk({nm, " wstrb"}, DmemWstrb, exp_strb);
            if (!is_load) chk({nm, " wdata"}, DmemWdata & bytemask(exp_strb), exp_wdata);
            chk({nm, " stall"}, StallReq, exp_stall);
            if (exp_stall) chk({nm, " rdwe_bubble"}, RdWriteEnableOut, 0);
            stalls += int'(StallReq);
            cyc();
        end
        DmemGnt = 0;
        if (is_load) begin
            for (int k = 0; k <= rv_dly; k++) begin
                DmemRvalid = (k == rv_dly);
                #4;
                chk({nm, " resp_stall"}, StallReq, 1);
                chk({nm, " resp_req"}, DmemReq, 0);
                chk({nm, " resp_rdwe"}, RdWriteEnableOut, 0);
                stalls += int'(StallReq);
                cyc();
            end
            DmemRvalid = 0;
            DmemRdata = ~rdata;
            #4;
            chk({nm, " load_data"}, RdWriteDataOut, exp_load);
            chk({nm, " rd_addr"}, RdAddrOut, rd);
            chk({nm, " rd_we"}, RdWriteEnableOut, 1);
            chk({nm, " done_stall"}, StallReq, 0);
            stalls += int'(StallReq);
            cyc();
        end
        ValidIn = 0; MemReadIn = 0; MemWriteIn = 0;
    endtask

    typedef struct {
        logic        valid;
        logic        store;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rdwe;
        logic        exp_req;
        logic        exp_rdwe;
        logic [63:0] exp_rddata;
        logic [63:0] exp_addr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int st;
        logic is_load;
        logic [2:0] f3;
        logic [63:0] a, sd, rdv;
        int gd, rv;

        vecs[0] = '{1'b1, 1'b0, F3_B, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h1234, 64'h0, 8'h00, 64'h0};
        vecs[1] = '{1'b0, 1'b0, F3_B, 64'hFFFF, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF, 64'h0, 8'h00, 64'h0};
        vecs[2] = '{1'b1, 1'b0, F3_B, 64'hCAFE, 64'h0, 5'd31, 1'b0, 1'b0, 1'b0, 64'hCAFE, 64'h0, 8'h00, 64'h0};
        vecs[3] = '{1'b1, 1'b1, F3_B, 64'h1007, 64'hAB, 5'd0, 1'b0, 1'b1, 1'b0, 64'h0,
                    64'h1000, 8'h80, 64'hAB00_0000_0000_0000};
        vecs[4] = '{1'b1, 1'b1, F3_H, 64'h6, 64'h1122_3344_5566_7788, 5'd0, 1'b0, 1'b1, 1'b0, 64'h0,
                    64'h0, 8'hC0, 64'h7788_0000_0000_0000};
        vecs[5] = '{1'b1, 1'b1, F3_D, 64'h8, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0, 1'b1, 1'b0, 64'h0,
                    64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF};

        idle_inputs();
        Rst = 1;
        ValidIn = 1; MemReadIn = 1; RdWriteEnableIn = 1; AluResultIn = 64'h55; RdAddrIn = 5'd9;
        DmemGnt = 1;
        #4;
        chk("rst stall", StallReq, 0);
        chk("rst req", DmemReq, 0);
        chk("rst we", DmemWe, 0);
        chk("rst wstrb", DmemWstrb, 0);
        chk("rst rdwe", RdWriteEnableOut, 0);
        chk("rst rddata", RdWriteDataOut, 0);
        chk("rst rdaddr", RdAddrOut, 0);
        cyc();
        cyc();
        idle_inputs();
        Rst = 0;
        cyc();

        for (int i = 0; i < 6; i++) begin
            ValidIn = vecs[i].valid; MemWriteIn = vecs[i].store; MemReadIn = 0;
            Funct3In = vecs[i].f3; AluResultIn = vecs[i].addr; StoreDataIn = vecs[i].data;
            RdAddrIn = vecs[i].rd; RdWriteEnableIn = vecs[i].rdwe; DmemGnt = 1;
            #4;
            chk($sformatf("vec%0d req", i), DmemReq, vecs[i].exp_req);
            chk($sformatf("vec%0d stall", i), StallReq, 0);
            chk($sformatf("vec%0d rdwe", i), RdWriteEnableOut, vecs[i].exp_rdwe);
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d addr", i), DmemAddr, vecs[i].exp_addr);
                chk($sformatf("vec%0d wstrb", i), DmemWstrb, vecs[i].exp_strb);
                chk($sformatf("vec%0d wdata", i), DmemWdata & bytemask(vecs[i].exp_strb), vecs[i].exp_wdata);
                chk($sformatf("vec%0d we", i), DmemWe, 1);
            end else begin
                chk($sformatf("vec%0d rddata", i), RdWriteDataOut, vecs[i].exp_rddata);
                chk($sformatf("vec%0d rdaddr", i), RdAddrOut, vecs[i].rd);
            end
            cyc();
            idle_inputs();
        end

        do_mem("lb", 1, F3_B, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 5'd4,
               64'h1000, 8'h08, 0, 64'hFFFF_FFFF_FFFF_FF80, st);
        chk("lb stall_cycles", st, 2);
        do_mem("sh", 0, F3_H, 64'h2002, 64'hBEEF, 0, 3, 0, 5'd0,
               64'h2000, 8'h0C, 64'h0000_0000_BEEF_0000, 0, st);
        chk("sh stall_cycles", st, 3);
        do_mem("lwu", 1, F3_WU, 64'h10, 0, 64'hFFFF_FFFF_AABB_CCDD, 1, 2, 5'd12,
               64'h10, 8'h0F, 0, 64'h0000_0000_AABB_CCDD, st);
        do_mem("ld", 1, F3_D, 64'h10, 0, 64'hFFFF_FFFF_AABB_CCDD, 0, 1, 5'd13,
               64'h10, 8'hFF, 0, 64'hFFFF_FFFF_AABB_CCDD, st);

`ifdef MISALIGN_TRAP_EN
        ValidIn = 1; MemReadIn = 1; Funct3In = F3_W; AluResultIn = 64'h3001; RdAddrIn = 5'd7;
        RdWriteEnableIn = 1; DmemGnt = 0;
        #4;
        chk("mis flag", MisalignOut, 1);
        chk("mis req", DmemReq, 0);
        chk("mis rdwe", RdWriteEnableOut, 0);
        chk("mis stall", StallReq, 0);
        cyc();
        idle_inputs();
`else
        do_mem("lw_mis", 1, F3_W, 64'h3001, 0, 64'h1122_3344_5566_7788, 0, 0, 5'd7,
               64'h3000, 8'h0F, 0, 64'h0000_0000_5566_7788, st);
`endif

        // Reset while waiting for rvalid; the late response must not write rd
        ValidIn = 1; MemReadIn = 1; Funct3In = F3_B; AluResultIn = 64'h40; RdAddrIn = 5'd8;
        RdWriteEnableIn = 1; DmemGnt = 1;
        #4;
        chk("rstresp issue_stall", StallReq, 1);
        cyc();
        DmemGnt = 0;
        #1;
        Rst = 1;
        #1;
        chk("rstresp stall", StallReq, 0);
        chk("rstresp req", DmemReq, 0);
        chk("rstresp rdwe", RdWriteEnableOut, 0);
        cyc();
        Rst = 0; ValidIn = 0; MemReadIn = 0; DmemRvalid = 1; DmemRdata = 64'h7F;
        #4;
        chk("rstresp late_rdwe", RdWriteEnableOut, 0);
        chk("rstresp late_stall", StallReq, 0);
        cyc();
        DmemRvalid = 0;
        #4;
        chk("rstresp nodone_rdwe", RdWriteEnableOut, 0);
        chk("rstresp nodone_stall", StallReq, 0);
        cyc();
        idle_inputs();

        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            a = {$urandom, $urandom};
            sd = {$urandom, $urandom};
            rdv = {$urandom, $urandom};
            gd = $urandom_range(0, 3);
            rv = $urandom_range(0, 2);
            if (kind == 0) begin
                ValidIn = 1; RdWriteEnableIn = 1; AluResultIn = a; RdAddrIn = 5'(n);
                #4;
                chk("rnd alu data", RdWriteDataOut, a);
                chk("rnd alu rdwe", RdWriteEnableOut, 1);
                chk("rnd alu req", DmemReq, 0);
                cyc();
                idle_inputs();
            end else begin
                is_load = (kind == 1);
                f3 = is_load ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
`ifdef MISALIGN_TRAP_EN
                a = a & ~(64'((1 << f3[1:0]) - 1));
`endif
                do_mem(is_load ? "rnd load" : "rnd store", is_load, f3, a, sd, rdv, gd, rv, 5'(n),
                       {a[63:3], 3'b000}, ref_strb(f3, a), ref_wdata(f3, a, sd),
                       ref_load(f3, a, rdv), st);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
